mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_picker.sv | 35 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the SIMD shared-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned NUM_PROC_DEF = 4;
  localparam int unsigned ADDR_W_DEF   = 32;

  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Width of a port index; at least one bit, even for a single port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned N     = NUM_PROC_DEF,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  int unsigned      k;
  logic [IDX_W-1:0] k_idx;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    k       = 0;
    k_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k     = (32'(ptr) + i) % N;
      k_idx = IDX_W'(k);
      if (!any_c && req[k_idx]) begin
        any_c          = 1'b1;
        grant_c[k_idx] = 1'b1;
        idx_c          = k_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NUM_PROC SIMD ports one shared memory port.
// Define MEM_ARB_WR_PRIORITY_EN to let any pending write beat all reads.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PROC = NUM_PROC_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = 128
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [NUM_PROC-1:0]          i_req_rd,
  input  logic [NUM_PROC-1:0]          i_req_wr,
  input  logic [NUM_PROC*ADDR_W-1:0]   i_addr,
  input  logic [NUM_PROC*DATA_W-1:0]   i_wdata,
  output logic [NUM_PROC-1:0]          o_grant_rd,
  output logic [NUM_PROC-1:0]          o_grant_wr,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [DATA_W-1:0]            o_mem_wdata,
  input  logic                         i_mem_ready,
  input  logic [DATA_W-1:0]            i_mem_rdata
);

  localparam int unsigned      IDX_W    = idx_w(NUM_PROC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROC - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d, win_q, win_d;
  logic                we_q, we_d, en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_PROC-1:0] grd_q, grd_d, gwr_q, gwr_d;

  logic [IDX_W-1:0]    start_c;
  logic [NUM_PROC-1:0] rd_grant_c, wr_grant_c, sel_grant_c;
  logic [IDX_W-1:0]    rd_idx_c, wr_idx_c, sel_idx_c;
  logic                rd_any_c, wr_any_c, sel_we_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_wdata_c;

  assign start_c = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

  rr_picker #(.N(NUM_PROC), .IDX_W(IDX_W)) u_rd_pick (
    .req(i_req_rd), .ptr(start_c), .grant_c(rd_grant_c), .idx_c(rd_idx_c), .any_c(rd_any_c)
  );

  rr_picker #(.N(NUM_PROC), .IDX_W(IDX_W)) u_wr_pick (
    .req(i_req_wr), .ptr(start_c), .grant_c(wr_grant_c), .idx_c(wr_idx_c), .any_c(wr_any_c)
  );

`ifdef MEM_ARB_WR_PRIORITY_EN
  // Any write anywhere outranks every read.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_grant_c = rd_grant_c;
    sel_idx_c   = rd_idx_c;
    if (wr_any_c) begin
      sel_we_c    = 1'b1;
      sel_grant_c = wr_grant_c;
      sel_idx_c   = wr_idx_c;
    end
  end
`else
  int unsigned rd_dist_c, wr_dist_c;

  // One shared rotation: the candidate closer to the pointer wins, read on a tie.
  always_comb begin
    rd_dist_c   = (32'(rd_idx_c) + NUM_PROC - 32'(start_c)) % NUM_PROC;
    wr_dist_c   = (32'(wr_idx_c) + NUM_PROC - 32'(start_c)) % NUM_PROC;
    sel_we_c    = 1'b0;
    sel_grant_c = rd_grant_c;
    sel_idx_c   = rd_idx_c;
    if (wr_any_c && (!rd_any_c || (wr_dist_c < rd_dist_c))) begin
      sel_we_c    = 1'b1;
      sel_grant_c = wr_grant_c;
      sel_idx_c   = wr_idx_c;
    end
  end
`endif

  // One-hot AND-OR mux of the winner's address and write data.
  logic [NUM_PROC:0][ADDR_W-1:0] addr_acc;
  logic [NUM_PROC:0][DATA_W-1:0] wdata_acc;
  assign addr_acc[0]  = '0;
  assign wdata_acc[0] = '0;
  for (genvar g = 0; g < NUM_PROC; g++) begin : g_mux
    assign addr_acc[g+1]  = addr_acc[g]  | (sel_grant_c[g] ? i_addr[g*ADDR_W +: ADDR_W]  : '0);
    assign wdata_acc[g+1] = wdata_acc[g] | (sel_grant_c[g] ? i_wdata[g*DATA_W +: DATA_W] : '0);
  end
  assign sel_addr_c  = addr_acc[NUM_PROC];
  assign sel_wdata_c = wdata_acc[NUM_PROC];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    en_d    = 1'b0;
    grd_d   = '0;
    gwr_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_any_c || wr_any_c) begin
          state_d = ST_ISSUE;
          win_d   = sel_idx_c;
          we_d    = sel_we_c;
          addr_d  = sel_addr_c;
          wdata_d = sel_wdata_c;
          en_d    = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_mem_ready) begin
          state_d = ST_RESP;
          last_d  = win_q;
          if (we_q) begin
            gwr_d[win_q] = 1'b1;
          end else begin
            grd_d[win_q] = 1'b1;
            rdata_d      = i_mem_rdata;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_IDX;
      win_q   <= '0;
      we_q    <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      grd_q   <= '0;
      gwr_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      grd_q   <= grd_d;
      gwr_q   <= gwr_d;
    end
  end

  assign o_grant_rd  = grd_q;
  assign o_grant_wr  = gwr_q;
  assign o_rdata     = rdata_q;
  assign o_mem_en    = en_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

endmodule
